fifo_reset_sequencer: RTL and testbench
=======================================

// Module: fifo_reset_sequencer
// PURPOSE
//  Orders reset release across the FIFO's downstream blocks after the synchronized reset.
//  Holds all stage resets, then releases them one at a time (stage 0 first).
//  Waits for each stage's init-done handshake before releasing the next stage.
//  Flags a fault on timeout or on loss of done. Supports a software re-sequence request.
// PARAMETERS
//  NUM_STAGES      4    number of sequenced reset domains (1..16)
//  HOLD_CYCLES     8    cycles all resets are held, and settle gap between stages (>=1)
//  TIMEOUT_CYCLES  256  max cycles in WAIT_DONE before fault (>=2)
// PORTS
//  clock           in   1                       single clock; all logic on posedge
//  reset           in   1                       synchronous, active-high; from aasd stage
//  soft_reset_req  in   1                       one-cycle pulse; restart full sequence
//  stage_done      in   NUM_STAGES              per-stage init complete; level, held while up
//  stage_reset     out  NUM_STAGES              per-stage reset, active-high, registered
//  busy            out  1                       sequence in progress (not RUN, not FAULT)
//  all_ready       out  1                       all stages released and done
//  fault           out  1                       sticky fault indication
//  fault_stage     out  $clog2(NUM_STAGES)+1    index of faulting stage
// BEHAVIOUR
//  Reset is synchronous and active-high. On reset, in the same edge: state=ASSERT_ALL, cnt=0,
//   stage_reset='1, busy=1, all_ready=0, fault=0, fault_stage=0, stage index k=0.
//  All outputs are registered. No combinational path from any input to any output.
//  States: ASSERT_ALL -> RELEASE -> WAIT_DONE -> SETTLE -> (RELEASE k+1 | RUN); plus FAULT.
//  ASSERT_ALL: cnt counts 0..HOLD_CYCLES-1, then goes to RELEASE.
//   First edge sampling reset=0 is E0. stage_reset[0] falls after edge E(HOLD_CYCLES).
//  RELEASE: clears stage_reset[k] (registered). Next state is WAIT_DONE, with cnt=0.
//  WAIT_DONE: stage_done[k] sampled high -> SETTLE, cnt=0.
//   If cnt reaches TIMEOUT_CYCLES-1 without done -> FAULT, fault_stage=k.
//   If done and timeout occur in the same cycle, done wins.
//  SETTLE: holds for HOLD_CYCLES cycles.
//   Then, if k==NUM_STAGES-1 -> RUN; otherwise k++ and go to RELEASE.
//  RUN: busy=0, all_ready=1. stage_reset stays 0.
//  Done-loss rule: in WAIT_DONE/SETTLE/RUN, any already-released stage j<k (all j in RUN)
//   with stage_done[j]=0 -> FAULT, fault_stage=lowest such j.
//   Done-loss takes priority over the timeout check.
//  FAULT: stage_reset='1, fault=1, busy=0, all_ready=0.
//   Sticky until reset or soft_reset_req.
//  soft_reset_req, any state: next state ASSERT_ALL, cnt=0, k=0, stage_reset='1.
//   Also clears fault and fault_stage=0, and sets busy=1.
//   In ASSERT_ALL it restarts the hold count.
//  Priority per edge: reset > soft_reset_req > done-loss fault > timeout > normal progress.
//  Width rules:
//   cnt width = $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES))+1; no wrap, saturating compare.
//   k width = $clog2(NUM_STAGES)+1 (safe for NUM_STAGES=1).
//  NUM_STAGES=1: RELEASE/WAIT_DONE/SETTLE run once, then RUN.
//  stage_done for unreleased stages (j>k) is ignored.
// STRUCTURE
//  Package fifo_rst_seq_pkg: typedef enum logic [2:0] rst_seq_state_t;
//   also the CNT_W/IDX_W width functions.
//  Sub-module rst_seq_timer: loadable up-counter with clear and terminal-count compare.
//   Shared by the hold, settle and timeout phases.
//  Top level: FSM, stage index register, per-stage reset register vector, fault capture.
// TESTING (NUM_STAGES=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=16)
//  Reset 3 cycles; done rises 2 cycles after each release.
//   -> stage_reset 111->110->100->000 at E4, E12, E20.
//   -> all_ready=1, busy=0 after E27.
//  Hold stage_done[1]=0 after release.
//   -> fault=1, fault_stage=1 at 16th WAIT_DONE cycle; stage_reset=111.
//  In RUN, drop stage_done[0] and [2] together -> FAULT with fault_stage=0, stage_reset=111.
//  In FAULT, pulse soft_reset_req -> next cycle fault=0, busy=1, stage_reset=111.
//   -> full sequence repeats with identical timing.
//  Assert reset mid-WAIT_DONE(k=1) -> next edge: stage_reset=111, k=0, all_ready=0, fault=0.
//  Done and timeout in the same cycle (done on cycle 15) -> SETTLE, no fault.

Source files
------------

// File: rtl/fifo_rst_seq_pkg.sv
// Shared types and width helpers for the FIFO reset sequencer and its timer.
package fifo_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT_ALL = 3'd0,
        ST_RELEASE    = 3'd1,
        ST_WAIT_DONE  = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } rst_seq_state_t;

    // One extra bit over the largest terminal count so the compare never wraps.
    function automatic int cnt_w(input int hold_cycles, input int timeout_cycles);
        int max_v;
        max_v = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
        return $clog2(max_v) + 1;
    endfunction

    function automatic int idx_w(input int num_stages);
        return $clog2(num_stages) + 1;
    endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable saturating up-counter with clear and terminal-count compare,
// shared by the hold, settle and timeout phases of the reset sequencer.
module rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] tc_i,
    output logic         at_tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_tc_o = (cnt_q >= tc_i);

endmodule

// File: rtl/fifo_reset_sequencer.sv
// Releases per-stage resets in order after the synchronized reset, waiting for
// each stage's init-done before moving on; faults on timeout or loss of done.
module fifo_reset_sequencer
    import fifo_rst_seq_pkg::*;
#(
    parameter  int NUM_STAGES     = 4,
    parameter  int HOLD_CYCLES    = 8,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = idx_w(NUM_STAGES),
    localparam int CNT_W          = cnt_w(HOLD_CYCLES, TIMEOUT_CYCLES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  busy,
    output logic                  all_ready,
    output logic                  fault,
    output logic [IDX_W-1:0]      fault_stage
);

    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    rst_seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]      k_q, k_d;
    logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
    logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;
    logic                  busy_q, busy_d;
    logic                  all_ready_q, all_ready_d;
    logic                  fault_q, fault_d;

    logic                  tmr_clr_s;
    logic                  tmr_inc_s;
    logic [CNT_W-1:0]      tmr_tc_s;
    logic                  tmr_at_tc_s;
    logic                  done_k_s;
    logic                  lost_s;
    logic [IDX_W-1:0]      lost_idx_s;

    rst_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .clr_i      (tmr_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (tmr_inc_s),
        .tc_i       (tmr_tc_s),
        .at_tc_o    (tmr_at_tc_s)
    );

    // Only WAIT_DONE runs against the timeout; every other timed phase uses the hold length.
    always_comb begin
        tmr_tc_s = HOLD_TC;
        if (state_q == ST_WAIT_DONE) begin
            tmr_tc_s = TMO_TC;
        end else begin
            tmr_tc_s = HOLD_TC;
        end
    end

    // Select done of the current stage and find the lowest released stage that lost done.
    always_comb begin
        done_k_s   = 1'b0;
        lost_s     = 1'b0;
        lost_idx_s = {IDX_W{1'b0}};
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (IDX_W'(j) == k_q) begin
                done_k_s = stage_done[j];
            end else begin
                done_k_s = done_k_s;
            end
            // Descending scan so the lowest offending index is the one kept.
            if (!stage_done[j] &&
                ((state_q == ST_RUN) ||
                 (((state_q == ST_WAIT_DONE) || (state_q == ST_SETTLE)) && (IDX_W'(j) < k_q)))) begin
                lost_s     = 1'b1;
                lost_idx_s = IDX_W'(j);
            end else begin
                lost_s     = lost_s;
            end
        end
    end

    // Next-state logic: soft request > done loss > timeout > normal progress.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        stage_reset_d = stage_reset_q;
        fault_stage_d = fault_stage_q;
        tmr_clr_s     = 1'b0;
        tmr_inc_s     = 1'b0;
        if (soft_reset_req) begin
            state_d       = ST_ASSERT_ALL;
            k_d           = {IDX_W{1'b0}};
            stage_reset_d = {NUM_STAGES{1'b1}};
            fault_stage_d = {IDX_W{1'b0}};
            tmr_clr_s     = 1'b1;
        end else if (lost_s) begin
            state_d       = ST_FAULT;
            stage_reset_d = {NUM_STAGES{1'b1}};
            fault_stage_d = lost_idx_s;
            tmr_clr_s     = 1'b1;
        end else begin
            case (state_q)
                ST_ASSERT_ALL: begin
                    if (tmr_at_tc_s) begin
                        state_d   = ST_RELEASE;
                        tmr_clr_s = 1'b1;
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    for (int j = 0; j < NUM_STAGES; j++) begin
                        if (IDX_W'(j) == k_q) begin
                            stage_reset_d[j] = 1'b0;
                        end else begin
                            stage_reset_d[j] = stage_reset_q[j];
                        end
                    end
                    state_d   = ST_WAIT_DONE;
                    tmr_clr_s = 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (done_k_s) begin
                        state_d   = ST_SETTLE;
                        tmr_clr_s = 1'b1;
                    end else if (tmr_at_tc_s) begin
                        state_d       = ST_FAULT;
                        stage_reset_d = {NUM_STAGES{1'b1}};
                        fault_stage_d = k_q;
                        tmr_clr_s     = 1'b1;
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_at_tc_s) begin
                        tmr_clr_s = 1'b1;
                        if (k_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_RELEASE;
                            k_d     = k_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tmr_inc_s = 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FAULT: begin
                    state_d       = ST_FAULT;
                    stage_reset_d = {NUM_STAGES{1'b1}};
                end
                default: begin
                    state_d       = ST_ASSERT_ALL;
                    k_d           = {IDX_W{1'b0}};
                    stage_reset_d = {NUM_STAGES{1'b1}};
                    tmr_clr_s     = 1'b1;
                end
            endcase
        end
    end

    // Status flags follow the state being entered so they register alongside it.
    always_comb begin
        busy_d      = (state_d != ST_RUN) && (state_d != ST_FAULT);
        all_ready_d = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    // State, stage index and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_ASSERT_ALL;
            k_q           <= {IDX_W{1'b0}};
            stage_reset_q <= {NUM_STAGES{1'b1}};
            fault_stage_q <= {IDX_W{1'b0}};
            busy_q        <= 1'b1;
            all_ready_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stage_reset_q <= stage_reset_d;
            fault_stage_q <= fault_stage_d;
            busy_q        <= busy_d;
            all_ready_q   <= all_ready_d;
            fault_q       <= fault_d;
        end
    end

    assign stage_reset = stage_reset_q;
    assign fault_stage = fault_stage_q;
    assign busy        = busy_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fifo_reset_sequencer.sv
// Directed and randomized bench for fifo_reset_sequencer, checked each cycle
// against a countdown-based reference model plus fixed-edge expectations.
module tb_fifo_reset_sequencer;

    localparam int NS   = 3;
    localparam int HOLD = 4;
    localparam int TMO  = 16;
    localparam int FW   = $clog2(NS) + 1;

    localparam int P_HOLD    = 0;
    localparam int P_RELEASE = 1;
    localparam int P_WAIT    = 2;
    localparam int P_SETTLE  = 3;
    localparam int P_RUN     = 4;
    localparam int P_FAULT   = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          soft_reset_req;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_reset;
    logic          busy;
    logic          all_ready;
    logic          fault;
    logic [FW-1:0] fault_stage;

    int vectors     = 0;
    int miscompares = 0;

    int            m_phase;
    int            m_left;
    int            m_k;
    int            m_fstage;
    int            seq_e;
    logic [NS-1:0] m_rst;
    int            mode;
    int            rel_cnt[NS];
    int            done_delay[NS];
    logic [NS-1:0] kill;

    always #5 clock = ~clock;

    fifo_reset_sequencer #(
        .NUM_STAGES     (NS),
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .soft_reset_req (soft_reset_req),
        .stage_done     (stage_done),
        .stage_reset    (stage_reset),
        .busy           (busy),
        .all_ready      (all_ready),
        .fault          (fault),
        .fault_stage    (fault_stage)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, seq_e);
        end
    endtask

    // Reference: each timed phase holds a remaining-cycles count that drains to zero.
    task automatic model_step();
        int lost;
        lost = -1;
        if (reset || soft_reset_req) begin
            m_phase  = P_HOLD;
            m_left   = HOLD;
            m_k      = 0;
            m_rst    = '1;
            m_fstage = 0;
            seq_e    = -1;
        end else begin
            seq_e++;
            for (int j = NS - 1; j >= 0; j--) begin
                if (!stage_done[j] && (m_phase == P_RUN ||
                    ((m_phase == P_WAIT || m_phase == P_SETTLE) && j < m_k)))
                    lost = j;
            end
            if (lost >= 0) begin
                m_phase  = P_FAULT;
                m_rst    = '1;
                m_fstage = lost;
            end else begin
                case (m_phase)
                    P_HOLD: begin
                        m_left--;
                        if (m_left == 0) m_phase = P_RELEASE;
                    end
                    P_RELEASE: begin
                        m_rst[m_k] = 1'b0;
                        m_phase    = P_WAIT;
                        m_left     = TMO;
                    end
                    P_WAIT: begin
                        if (stage_done[m_k]) begin
                            m_phase = P_SETTLE;
                            m_left  = HOLD;
                        end else begin
                            m_left--;
                            if (m_left == 0) begin
                                m_phase  = P_FAULT;
                                m_rst    = '1;
                                m_fstage = m_k;
                            end
                        end
                    end
                    P_SETTLE: begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_k == NS - 1) begin
                                m_phase = P_RUN;
                            end else begin
                                m_k++;
                                m_phase = P_RELEASE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        chk("stage_reset", 32'(stage_reset), 32'(m_rst));
        chk("busy",        32'(busy),        32'(m_phase != P_RUN && m_phase != P_FAULT));
        chk("all_ready",   32'(all_ready),   32'(m_phase == P_RUN));
        chk("fault",       32'(fault),       32'(m_phase == P_FAULT));
        chk("fault_stage", 32'(fault_stage), 32'(m_fstage));
    endtask

    // Fixed-edge expectations for the documented timing scenarios.
    task automatic seq_check();
        if (mode == 1) begin
            case (seq_e)
                3:  chk("E3 hold",   32'(stage_reset), 32'(3'b111));
                4:  chk("E4 rel0",   32'(stage_reset), 32'(3'b110));
                11: chk("E11 hold0", 32'(stage_reset), 32'(3'b110));
                12: chk("E12 rel1",  32'(stage_reset), 32'(3'b100));
                19: chk("E19 hold1", 32'(stage_reset), 32'(3'b100));
                20: chk("E20 rel2",  32'(stage_reset), 32'(3'b000));
                26: chk("E26 not ready", 32'({busy, all_ready}), 32'(2'b10));
                27: chk("E27 ready",     32'({busy, all_ready}), 32'(2'b01));
                default: ;
            endcase
        end else if (mode == 2) begin
            case (seq_e)
                27: chk("E27 no fault yet", 32'(fault), 32'(1'b0));
                28: chk("E28 timeout fault", 32'({fault, fault_stage, stage_reset}),
                        32'({1'b1, 3'd1, 3'b111}));
                default: ;
            endcase
        end else if (mode == 3) begin
            case (seq_e)
                28: chk("E28 done wins", 32'({fault, busy}), 32'(2'b01));
                32: chk("E32 settle1",   32'(stage_reset), 32'(3'b100));
                33: chk("E33 rel2",      32'(stage_reset), 32'(3'b000));
                default: ;
            endcase
        end
    endtask

    task automatic drive_done();
        for (int j = 0; j < NS; j++) begin
            if (m_rst[j])
                stage_done[j] = 1'($urandom_range(0, 1));
            else
                stage_done[j] = !kill[j] && done_delay[j] >= 0 && rel_cnt[j] > done_delay[j];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
        seq_check();
        for (int j = 0; j < NS; j++) begin
            if (m_rst[j]) rel_cnt[j] = 0;
            else          rel_cnt[j]++;
        end
        drive_done();
    endtask

    task automatic set_delays(input int d0, input int d1, input int d2);
        done_delay[0] = d0;
        done_delay[1] = d1;
        done_delay[2] = d2;
    endtask

    initial begin
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        stage_done     = '0;
        kill           = '0;
        mode           = 1;
        seq_e          = -1;
        m_phase        = P_HOLD;
        m_left         = HOLD;
        m_k            = 0;
        m_rst          = '1;
        m_fstage       = 0;
        for (int j = 0; j < NS; j++) rel_cnt[j] = 0;
        set_delays(2, 2, 2);

        // Nominal sequence after a 3-cycle reset.
        repeat (3) tick();
        chk("reset state", 32'({stage_reset, busy, all_ready, fault, fault_stage}),
            32'({3'b111, 1'b1, 1'b0, 1'b0, 3'd0}));
        reset = 1'b0;
        repeat (32) tick();

        // Drop done of stages 0 and 2 together while running.
        mode = 0;
        kill = 3'b101;
        drive_done();
        tick();
        chk("run drop 0+2", 32'({fault, fault_stage, stage_reset}), 32'({1'b1, 3'd0, 3'b111}));
        repeat (5) tick();
        chk("fault sticky", 32'({fault, busy, all_ready}), 32'(3'b100));

        // Soft re-sequence from FAULT, then the same timing again.
        kill           = '0;
        mode           = 1;
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        chk("soft clears", 32'({fault, busy, stage_reset, fault_stage}),
            32'({1'b0, 1'b1, 3'b111, 3'd0}));
        repeat (32) tick();

        // Stage 1 never reports done: timeout fault.
        mode = 2;
        set_delays(2, -1, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (32) tick();

        // Done arrives on the last timeout cycle: done wins.
        mode = 3;
        set_delays(2, 15, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (40) tick();

        // Reset in the middle of WAIT_DONE for stage 1, then a clean sequence.
        mode = 0;
        set_delays(2, -1, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (16) tick();
        reset = 1'b1;
        tick();
        chk("mid reset", 32'({stage_reset, all_ready, fault, busy}),
            32'({3'b111, 1'b0, 1'b0, 1'b1}));
        reset = 1'b0;
        mode  = 1;
        set_delays(2, 2, 2);
        repeat (30) tick();

        // Randomized done latencies, drops and soft requests.
        mode = 0;
        for (int it = 0; it < 20; it++) begin
            for (int j = 0; j < NS; j++) begin
                case ($urandom_range(0, 7))
                    0:       done_delay[j] = -1;
                    1:       done_delay[j] = 20;
                    default: done_delay[j] = int'($urandom_range(0, 6));
                endcase
            end
            kill = '0;
            if (it % 2 == 0) reset = 1'b1;
            else             soft_reset_req = 1'b1;
            tick();
            reset          = 1'b0;
            soft_reset_req = 1'b0;
            repeat (60) begin
                if ($urandom_range(0, 99) < 2) kill = kill | (NS'(1) << $urandom_range(0, NS - 1));
                if ($urandom_range(0, 99) < 3) kill = '0;
                soft_reset_req = ($urandom_range(0, 199) == 0);
                drive_done();
                tick();
                soft_reset_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
